cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: DW, default 9, operand width in bits.
REQ-002 Parameter: NREQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst, input, 1; reset is synchronous and active-high.
REQ-005 Port: req_valid, input, NREQ, per-requester request pending.
REQ-006 Port: req_ready, output, NREQ, per-requester accept strobe.
REQ-007 Port: req_a, input, NREQ*DW, packed operand a; requester i uses bits [i*DW +: DW].
REQ-008 Port: req_b, input, NREQ*DW, packed operand b; same packing as req_a.
REQ-009 Port: resp_valid, output, 1, result available.
REQ-010 Port: resp_ready, input, 1, consumer accepts result.
REQ-011 Port: resp_id, output, 2, index of the requester that owns the result.
REQ-012 Port: resp_le, output, 1, result bit: 1 when a <= b (unsigned), else 0.
REQ-013 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 Port: done_cnt, output, 16, count of completed response handshakes.

Function
REQ-015 The FSM SHALL have four states: IDLE, CMP, WAIT, RESP.
REQ-016 In IDLE with any req_valid high, the block SHALL grant exactly one requester round-robin, searching from last_grant+1 mod 4, and assert only that requester's req_ready, combinationally.
REQ-017 req_ready SHALL be all-zero in every state except IDLE, and all-zero in IDLE when no req_valid is high.
REQ-018 On a req_valid & req_ready handshake, the block SHALL latch that requester's a, b and index into operand/id registers, set last_grant to the granted index, and go to CMP.
REQ-019 In CMP, the operand registers SHALL drive the comparator; the next edge SHALL go to WAIT.
REQ-020 In WAIT, the comparator output SHALL be captured into resp_le, and the next edge SHALL go to RESP.
REQ-021 In RESP, resp_valid SHALL be 1, with resp_id and resp_le held stable until resp_ready is high.
REQ-022 On the resp_valid & resp_ready handshake, the block SHALL go to IDLE and increment done_cnt by 1, wrapping from 0xFFFF to 0.
REQ-023 Latency: if accept occurs at edge k, resp_valid SHALL be high after edge k+2; a new accept SHALL NOT occur in the same cycle as a response handshake.
REQ-024 Comparison SHALL be unsigned over the full DW bits; a == b SHALL yield resp_le = 1.
REQ-025 Operand registers SHALL NOT change outside an IDLE accept; requester inputs changing after accept SHALL NOT affect the result.
REQ-026 A requester that deasserts req_valid before grant SHALL lose its slot without side effects.

Reset
REQ-027 When rst is high at an edge, the block SHALL set: state = IDLE; resp_valid = 0; resp_le = 0; resp_id = 0; busy = 0; done_cnt = 0; operand registers = 0; last_grant = 3, so that requester 0 has priority first.
REQ-028 Reset asserted in any state, including mid-transaction, SHALL discard the in-flight transaction with no response.
REQ-029 The comparator's internal register has no reset; its value SHALL be used only in WAIT, so a stale value after reset is never observable.

Structure
REQ-030 Package cmp_arb_pkg SHALL hold the state enum, NREQ = 4, ID_W = 2 and CNT_W = 16.
REQ-031 The block SHALL instantiate the existing comparator block once, with Nbits = DW-1, as its sole sub-module; no other compare logic is permitted.

Verification (DW = 9)
REQ-032 Single request: req0 with a = 5, b = 9 -> req_ready[0] high in the accept cycle; resp_valid high 2 edges later; resp_id = 0; resp_le = 1; done_cnt = 1.
REQ-033 Boundary values: a = 511, b = 511 -> resp_le = 1; then a = 256, b = 255 -> resp_le = 0; then a = 0, b = 0 -> resp_le = 1.
REQ-034 All four req_valid held high continuously, resp_ready = 1 -> grant/resp_id order 0, 1, 2, 3, 0; busy low exactly one cycle between transactions.
REQ-035 Backpressure: resp_ready held low 5 cycles in RESP -> resp_valid, resp_id and resp_le stable; req_ready = 0000 throughout; done_cnt unchanged until the handshake.
REQ-036 rst pulsed while in WAIT with req2 in flight -> next cycle resp_valid = 0 and busy = 0; no response for req2; next accept with req0 and req2 both valid grants req0.
REQ-037 done_cnt preloaded via 65535 transactions (or forced to 0xFFFF) -> one more handshake yields done_cnt = 0.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared types and sizes for the compare arbiter
package cmp_arb_pkg;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_arbiter_if.sv
// rtl/cmp_arbiter_if.sv - request/response bundle between requesters and the compare arbiter
interface cmp_arbiter_if #(
  parameter int DW   = 9,
  parameter int NREQ = cmp_arb_pkg::NREQ
) ();

  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [NREQ*DW-1:0]             req_a;
  logic [NREQ*DW-1:0]             req_b;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [cmp_arb_pkg::ID_W-1:0]   resp_id;
  logic                           resp_le;
  logic                           busy;
  logic [cmp_arb_pkg::CNT_W-1:0]  done_cnt;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_le, busy, done_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_le, busy, done_cnt
  );

endinterface

// File: rtl/cmp_arbiter_comparator.sv
// rtl/cmp_arbiter_comparator.sv - registered unsigned less-or-equal comparator over Nbits+1 bits
module cmp_arbiter_comparator #(
  parameter int Nbits = 8
) (
  input  logic           clk,
  input  logic [Nbits:0] a,
  input  logic [Nbits:0] b,
  output logic           le
);

  logic le_d;
  logic le_q;

  // unsigned a <= b, equality counts as less-or-equal
  always_comb begin
    le_d = (a <= b);
  end

  // result register carries no reset; the consumer only samples it once operands have settled
  always_ff @(posedge clk) begin
    le_q <= le_d;
  end

  assign le = le_q;

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter feeding one shared comparator, one transaction at a time
module cmp_arbiter #(
  parameter int DW   = 9,
  parameter int NREQ = cmp_arb_pkg::NREQ
) (
  input logic          clk,
  input logic          rst,
  cmp_arbiter_if.slave bus
);

  import cmp_arb_pkg::*;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DW-1:0]     op_a_q, op_a_d;
  logic [DW-1:0]     op_b_q, op_b_d;
  logic              resp_le_q, resp_le_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic [NREQ-1:0]   req_ready_c;
  logic              cmp_le;

  cmp_arbiter_comparator #(
    .Nbits (DW-1)
  ) u_cmp (
    .clk (clk),
    .a   (op_a_q),
    .b   (op_b_q),
    .le  (cmp_le)
  );

  // round-robin search starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last_grant_q + ID_W'(i);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // next-state, operand capture and ready strobes; ready only ever asserted while idle
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    resp_le_d    = resp_le_q;
    done_cnt_d   = done_cnt_q;
    req_ready_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          op_a_d       = bus.req_a[int'(gnt_idx)*DW +: DW];
          op_b_d       = bus.req_b[int'(gnt_idx)*DW +: DW];
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = CMP;
        end
      end
      CMP: begin
        state_d = WAIT;
      end
      WAIT: begin
        resp_le_d = cmp_le;
        state_d   = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NREQ-1);
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_le_q    <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_le_q    <= resp_le_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_le    = resp_le_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - randomized scoreboard bench for cmp_arbiter
module tb_cmp_arbiter;

  import cmp_arb_pkg::*;

  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cmp_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus();

  cmp_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int id;
    int le;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] a_arr [NREQ];
  logic [DW-1:0] b_arr [NREQ];

  int m_last;
  bit m_inflight;
  int m_age;
  int m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr, input logic r);
    logic [3:0] exp_rdy;
    int g;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*DW +: DW] = a_arr[i];
      bus.req_b[i*DW +: DW] = b_arr[i];
    end
    bus.req_valid  = v;
    bus.resp_ready = rr;
    rst            = r;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!m_inflight && v != 4'b0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (g < 0 && v[c]) g = c;
      end
      exp_rdy[g] = 1'b1;
    end
    chk("req_ready", {28'b0, bus.req_ready}, {28'b0, exp_rdy});
    chk("busy", {31'b0, bus.busy}, {31'b0, m_inflight});
    chk("resp_valid", {31'b0, bus.resp_valid}, (m_inflight && m_age >= 2) ? 32'd1 : 32'd0);
    chk("done_cnt", {16'b0, bus.done_cnt}, m_done);
    if (r) begin
      m_inflight = 1'b0;
      m_last     = NREQ - 1;
      m_done     = 0;
      sb.delete();
    end else if (g >= 0) begin
      e.id  = g;
      e.le  = (a_arr[g] <= b_arr[g]) ? 1 : 0;
      e.cnt = m_done;
      sb.push_back(e);
      m_last     = g;
      m_inflight = 1'b1;
      m_age      = 0;
    end else if (m_inflight) begin
      if (m_age >= 2 && rr) begin
        m_inflight = 1'b0;
        m_done     = (m_done + 1) % 65536;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one_txn(input int id, input int a, input int b);
    a_arr[id] = a[DW-1:0];
    b_arr[id] = b[DW-1:0];
    step(4'(1 << id), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0, 1'b1, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.resp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp actual=id%0d required=none at %0t", bus.resp_id, $time);
        end else begin
          chk("resp_id", {30'b0, bus.resp_id}, sb[0].id);
          chk("resp_le", {31'b0, bus.resp_le}, sb[0].le);
          if (bus.resp_ready) begin
            chk("done_cnt_at_hs", {16'b0, bus.done_cnt}, sb[0].cnt);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    m_last     = NREQ - 1;
    m_inflight = 1'b0;
    m_age      = 0;
    m_done     = 0;

    @(negedge clk);
    step(4'b0, 1'b0, 1'b1);
    step(4'b0, 1'b0, 1'b1);
    chk("rst_resp_id", {30'b0, bus.resp_id}, 0);
    chk("rst_resp_le", {31'b0, bus.resp_le}, 0);

    one_txn(0, 5, 9);
    chk("single_done_cnt", {16'b0, bus.done_cnt}, 1);

    one_txn(0, 511, 511);
    one_txn(0, 256, 255);
    one_txn(0, 0, 0);

    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = DW'(i * 37);
      b_arr[i] = DW'(100);
    end
    for (int i = 0; i < 20; i++) step(4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0, 1'b1, 1'b0);

    a_arr[1] = 9'd300;
    b_arr[1] = 9'd299;
    step(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(4'hF, 1'b0, 1'b0);
    step(4'b0, 1'b1, 1'b0);
    step(4'b0, 1'b1, 1'b0);

    a_arr[2] = 9'd17;
    b_arr[2] = 9'd18;
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0, 1'b1, 1'b0);
    step(4'b0, 1'b1, 1'b1);
    a_arr[0] = 9'd400;
    b_arr[0] = 9'd3;
    step(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0, 1'b1, 1'b0);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = DW'($urandom);
        b_arr[i] = ($urandom_range(0, 3) == 0) ? a_arr[i] : DW'($urandom);
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 6; i++) step(4'b0, 1'b1, 1'b0);

    force dut.done_cnt_q = 16'hFFFF;
    m_done = 65535;
    step(4'b0, 1'b1, 1'b0);
    release dut.done_cnt_q;
    step(4'b0, 1'b1, 1'b0);
    one_txn(3, 12, 12);
    chk("done_cnt_wrap", {16'b0, bus.done_cnt}, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
